mem_access_ctrl: RTL and testbench
==================================

Name: mem_access_ctrl

Overview:
- Sequences the data-memory access for the instruction held in the EX/MEM pipeline register.
- Converts the register's address, store data, width and read/write controls into a req/ack data-bus transaction with byte enables.
- Stalls the pipeline until the transaction completes, then returns aligned and extended load data to the MEM/WB path.
- Sits between the EX/MEM register outputs and the data-memory bus.

Parameters:
- MAX_WAIT, 15: maximum BUSY cycles without bus_ack_i before the transaction is aborted with err_o.
- CNT_W, 4: width of the wait counter; must satisfy 2^CNT_W > MAX_WAIT.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- mem_read_ctrl_i  in  1  load request from EX/MEM, active high
- mem_write_ctrl_i  in  1  store request from EX/MEM, active high
- wr_width_i  in  3  funct3 width: 000 B, 001 H, 010 W, 100 BU, 101 HU
- addr_i  in  32  byte address (ALU result)
- w_data_i  in  32  store data (rs2 value)
- bus_req_o  out  1  bus request, held until ack or abort
- bus_we_o  out  1  1 = write, 0 = read
- bus_addr_o  out  32  word address ({addr[31:2],2'b00})
- bus_be_o  out  4  byte enables
- bus_wdata_o  out  32  lane-replicated store data
- bus_ack_i  in  1  bus completion, one cycle
- bus_rdata_i  in  32  read data, valid with bus_ack_i
- stall_o  out  1  freeze PC and all pipeline registers up to and including EX/MEM
- rdata_o  out  32  aligned, extended load result
- rdata_valid_o  out  1  one-cycle pulse, rdata_o valid
- err_o  out  1  one-cycle pulse on timeout abort
- misalign_o  out  1  one-cycle pulse on a misaligned access (feature only)

Behaviour:
- Clock and reset: single clock clk; reset rst_n is asynchronous, active low.
- Reset:
  - State goes to IDLE and the counter clears.
  - All registered outputs go to 0, including bus_req_o.
  - Reset asserted mid-transaction drops bus_req_o immediately; the in-flight access is abandoned.
- States:
  - IDLE. A request is present when read or write is high.
    - stall_o = request (combinational).
    - On a request: latch we, bus_addr, bus_be, bus_wdata, width and addr[1:0]; clear the counter; go to BUSY.
    - If read and write are both high, the write wins.
  - BUSY.
    - bus_req_o = 1, stall_o = 1, bus outputs held stable.
    - On bus_ack_i = 1: capture the extracted load data; go to DONE.
    - Otherwise the counter increments. When counter == MAX_WAIT without ack, go to DONE flagged as an error.
  - DONE.
    - stall_o = 0, bus_req_o = 0.
    - Pulse rdata_valid_o (successful load) or err_o (abort).
    - Inputs are ignored, because EX/MEM still holds the completed instruction. Always return to IDLE.
- Latency:
  - With ack in the first BUSY cycle: stall_o is high for 2 cycles (IDLE, BUSY) and rdata_valid_o pulses in cycle 3.
  - Each extra ack-wait cycle adds 1 stall cycle.
- bus_ack_i outside BUSY is ignored.
- Byte enables and store data:
  - B: be = 4'b0001 << addr[1:0], wdata = {4{w_data[7:0]}}.
  - H: be = addr[1] ? 4'b1100 : 4'b0011, wdata = {2{w_data[15:0]}}.
  - W: be = 4'b1111, wdata = w_data.
  - Reads drive be = 4'b1111.
  - Widths 011/110/111 are treated as W.
- Load extraction:
  - Select the byte or half by addr[1:0] / addr[1].
  - B and H are sign-extended; BU and HU are zero-extended.
  - On abort, rdata_o = 0.
  - rdata_o holds its value until the next load completes.
- Writes never pulse rdata_valid_o.

Optional Feature:
- Macro: MEM_MISALIGN_CHK_EN.
- Defined:
  - A half access with addr[0] = 1, or a word access with addr[1:0] != 0, issues no bus transaction.
  - IDLE goes directly to DONE, giving a 1-cycle stall.
  - misalign_o pulses in DONE; rdata_valid_o stays 0.
- Undefined:
  - misalign_o is tied 0.
  - Offending low address bits are ignored: H uses addr[1] only, W uses the lane at addr[1:0] = 0.

Test Plan:
- Reset mid-BUSY with rst_n low 1 cycle -> bus_req_o drops in the same cycle, all outputs 0, state IDLE, no rdata_valid_o.
- SB with addr 0x1003, w_data 0x000000A5, ack after 0 waits -> bus_be_o = 1000, bus_wdata_o = 0xA5A5A5A5, bus_addr_o = 0x1000, bus_we_o = 1, stall_o high exactly 2 cycles.
- LB / LBU at addr 0x2002 with bus_rdata_i = 0x00F30000 -> rdata_o = 0xFFFFFFF3 (LB) and 0x000000F3 (LBU); LH at 0x2002 with rdata 0x80010000 -> 0xFFFF8001.
- LW with ack delayed 5 cycles -> stall_o high 7 cycles, bus signals stable throughout, rdata_valid_o pulses once.
- No ack with MAX_WAIT = 15 -> err_o pulses once after 15 BUSY cycles, rdata_o = 0, back to IDLE; a following request starts normally.
- With MEM_MISALIGN_CHK_EN defined, SW at addr 0x3002 -> bus_req_o never asserts, misalign_o pulses once, stall_o high 1 cycle.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// Data-memory access sequencer for the EX/MEM instruction: req/ack bus transaction, pipeline stall, load alignment.
// Optional misaligned-access trap enabled by defining MEM_MISALIGN_CHK_EN.
module mem_access_ctrl #(
    parameter int MAX_WAIT = 15,
    parameter int CNT_W    = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_read_ctrl_i,
    input  logic        mem_write_ctrl_i,
    input  logic [2:0]  wr_width_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] w_data_i,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [3:0]  bus_be_o,
    output logic [31:0] bus_wdata_o,
    input  logic        bus_ack_i,
    input  logic [31:0] bus_rdata_i,
    output logic        stall_o,
    output logic [31:0] rdata_o,
    output logic        rdata_valid_o,
    output logic        err_o,
    output logic        misalign_o
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WAIT);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             bus_req_q, bus_req_d;
    logic             bus_we_q, bus_we_d;
    logic [31:0]      bus_addr_q, bus_addr_d;
    logic [3:0]       bus_be_q, bus_be_d;
    logic [31:0]      bus_wdata_q, bus_wdata_d;
    logic [2:0]       width_q, width_d;
    logic [1:0]       off_q, off_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             rdata_valid_q, rdata_valid_d;
    logic             err_q, err_d;
    logic             misalign_q, misalign_d;

    logic        req, is_byte, is_half, mis;
    logic [3:0]  be_st;
    logic [31:0] wdata_st;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;

    assign req     = mem_read_ctrl_i | mem_write_ctrl_i;
    assign is_byte = (wr_width_i[1:0] == 2'b00);
    assign is_half = (wr_width_i[1:0] == 2'b01);

`ifdef MEM_MISALIGN_CHK_EN
    assign mis = (is_half && addr_i[0]) || (!is_byte && !is_half && (addr_i[1:0] != 2'b00));
`else
    assign mis = 1'b0;
`endif

    // Store lanes: narrow data is replicated so the slave just honours the byte enables.
    always_comb begin
        if (is_byte) begin
            be_st    = 4'b0001 << addr_i[1:0];
            wdata_st = {4{w_data_i[7:0]}};
        end else if (is_half) begin
            be_st    = addr_i[1] ? 4'b1100 : 4'b0011;
            wdata_st = {2{w_data_i[15:0]}};
        end else begin
            be_st    = 4'b1111;
            wdata_st = w_data_i;
        end
    end

    always_comb begin
        ld_byte = bus_rdata_i[{off_q, 3'b000} +: 8];
        ld_half = off_q[1] ? bus_rdata_i[31:16] : bus_rdata_i[15:0];
        case (width_q)
            3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'b100:  ld_data = {24'h0, ld_byte};
            3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
            3'b101:  ld_data = {16'h0, ld_half};
            default: ld_data = bus_rdata_i;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        bus_req_d     = bus_req_q;
        bus_we_d      = bus_we_q;
        bus_addr_d    = bus_addr_q;
        bus_be_d      = bus_be_q;
        bus_wdata_d   = bus_wdata_q;
        width_d       = width_q;
        off_d         = off_q;
        rdata_d       = rdata_q;
        rdata_valid_d = 1'b0;
        err_d         = 1'b0;
        misalign_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    bus_we_d    = mem_write_ctrl_i;
                    bus_addr_d  = {addr_i[31:2], 2'b00};
                    bus_be_d    = mem_write_ctrl_i ? be_st : 4'b1111;
                    bus_wdata_d = wdata_st;
                    width_d     = wr_width_i;
                    off_d       = addr_i[1:0];
                    cnt_d       = '0;
                    if (mis) begin
                        misalign_d = 1'b1;
                        state_d    = DONE;
                    end else begin
                        bus_req_d = 1'b1;
                        state_d   = BUSY;
                    end
                end
            end
            BUSY: begin
                if (bus_ack_i) begin
                    bus_req_d = 1'b0;
                    state_d   = DONE;
                    if (!bus_we_q) begin
                        rdata_d       = ld_data;
                        rdata_valid_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_d == MAX_CNT) begin
                        bus_req_d = 1'b0;
                        err_d     = 1'b1;
                        rdata_d   = '0;
                        state_d   = DONE;
                    end
                end
            end
            // EX/MEM still holds the finished instruction here, so inputs are not looked at.
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            bus_req_q     <= 1'b0;
            bus_we_q      <= 1'b0;
            bus_addr_q    <= '0;
            bus_be_q      <= '0;
            bus_wdata_q   <= '0;
            width_q       <= '0;
            off_q         <= '0;
            rdata_q       <= '0;
            rdata_valid_q <= 1'b0;
            err_q         <= 1'b0;
            misalign_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            bus_req_q     <= bus_req_d;
            bus_we_q      <= bus_we_d;
            bus_addr_q    <= bus_addr_d;
            bus_be_q      <= bus_be_d;
            bus_wdata_q   <= bus_wdata_d;
            width_q       <= width_d;
            off_q         <= off_d;
            rdata_q       <= rdata_d;
            rdata_valid_q <= rdata_valid_d;
            err_q         <= err_d;
            misalign_q    <= misalign_d;
        end
    end

    // Stall is gated by reset so a held EX/MEM request cannot freeze the pipe while in reset.
    assign stall_o       = rst_n && (((state_q == IDLE) && req) || (state_q == BUSY));
    assign bus_req_o     = bus_req_q;
    assign bus_we_o      = bus_we_q;
    assign bus_addr_o    = bus_addr_q;
    assign bus_be_o      = bus_be_q;
    assign bus_wdata_o   = bus_wdata_q;
    assign rdata_o       = rdata_q;
    assign rdata_valid_o = rdata_valid_q;
    assign err_o         = err_q;
    assign misalign_o    = misalign_q;
endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed scenarios plus randomized transactions
// checked against a lane-level behavioural model.
module tb_mem_access_ctrl;
    localparam int MAX_WAIT = 15;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_read_ctrl_i, mem_write_ctrl_i;
    logic [2:0]  wr_width_i;
    logic [31:0] addr_i, w_data_i;
    logic        bus_req_o, bus_we_o;
    logic [31:0] bus_addr_o;
    logic [3:0]  bus_be_o;
    logic [31:0] bus_wdata_o;
    logic        bus_ack_i;
    logic [31:0] bus_rdata_i;
    logic        stall_o;
    logic [31:0] rdata_o;
    logic        rdata_valid_o, err_o, misalign_o;

    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] model_rdata;

    always #5 clk = ~clk;

    mem_access_ctrl #(.MAX_WAIT(MAX_WAIT), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_read_ctrl_i(mem_read_ctrl_i), .mem_write_ctrl_i(mem_write_ctrl_i),
        .wr_width_i(wr_width_i), .addr_i(addr_i), .w_data_i(w_data_i),
        .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
        .bus_be_o(bus_be_o), .bus_wdata_o(bus_wdata_o),
        .bus_ack_i(bus_ack_i), .bus_rdata_i(bus_rdata_i),
        .stall_o(stall_o), .rdata_o(rdata_o), .rdata_valid_o(rdata_valid_o),
        .err_o(err_o), .misalign_o(misalign_o)
    );

    // ---------------- behavioural model ----------------
    function automatic int acc_size(input logic [2:0] w);
        case (w)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            default:        return 4;
        endcase
    endfunction

    function automatic int lane_base(input logic [2:0] w, input logic [31:0] a);
        int sz;
        sz = acc_size(w);
        return (int'(a[1:0]) / sz) * sz;
    endfunction

    function automatic logic [3:0] model_be(input logic [2:0] w, input logic [31:0] a, input logic is_wr);
        logic [3:0] be;
        int sz, base;
        be = 4'hF;
        if (is_wr) begin
            sz = acc_size(w);
            base = lane_base(w, a);
            for (int l = 0; l < 4; l++) be[l] = (l >= base) && (l < base + sz);
        end
        return be;
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] w, input logic [31:0] d);
        logic [31:0] r;
        int sz;
        sz = acc_size(w);
        for (int l = 0; l < 4; l++) r[8*l +: 8] = d[8*(l % sz) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] w, input logic [31:0] a, input logic [31:0] rd);
        logic [31:0] v, mask;
        int sz;
        sz = acc_size(w);
        v = rd >> (8 * lane_base(w, a));
        if (sz < 4) begin
            mask = (32'h1 << (8 * sz)) - 32'h1;
            v = v & mask;
            if (!w[2] && v[8*sz-1]) v = v | ~mask;
        end
        return v;
    endfunction

    function automatic bit model_misaligned(input logic [2:0] w, input logic [31:0] a);
`ifdef MEM_MISALIGN_CHK_EN
        int sz;
        sz = acc_size(w);
        return (sz == 2 && a[0]) || (sz == 4 && a[1:0] != 2'b00);
`else
        return (w == 3'b111) && (a == 32'h0) && 1'b0;
`endif
    endfunction

    // ---------------- transaction driver + checker ----------------
    // Entered and left 1 time unit after a rising edge with the DUT in IDLE.
    task automatic run_txn(input logic rd, input logic wr, input logic [2:0] w, input logic [31:0] a,
                           input logic [31:0] wd, input int dly, input logic [31:0] rdat);
        logic [31:0] addr_e, wdata_e, new_rdata;
        logic [3:0]  be_e;
        bit          mis_e, tmo_e, done;
        int          stall_e, stall_n, k;
        addr_e  = {a[31:2], 2'b00};
        be_e    = model_be(w, a, wr);
        wdata_e = model_wdata(w, wd);
        mis_e   = model_misaligned(w, a);
        tmo_e   = !mis_e && (dly >= MAX_WAIT);
        stall_e = mis_e ? 1 : (tmo_e ? MAX_WAIT + 1 : dly + 2);
        new_rdata = model_rdata;
        if (tmo_e) new_rdata = 32'h0;
        else if (!mis_e && !wr) new_rdata = model_load(w, a, rdat);
        stall_n = 0;
        k = 0;
        done = 0;
        mem_read_ctrl_i = rd; mem_write_ctrl_i = wr; wr_width_i = w; addr_i = a; w_data_i = wd;
        while (!done && k < 40) begin
            k++;
            bus_ack_i   = !tmo_e && !mis_e && (k == dly + 2);
            bus_rdata_i = bus_ack_i ? rdat : $urandom;
            @(negedge clk);
            if (stall_o) begin
                stall_n++;
                vectors++;
                if ((k >= 2 && (bus_req_o !== 1'b1 || bus_we_o !== wr || bus_addr_o !== addr_e ||
                                bus_be_o !== be_e || (wr && bus_wdata_o !== wdata_e))) ||
                    (k == 1 && bus_req_o !== 1'b0) ||
                    rdata_valid_o !== 1'b0 || err_o !== 1'b0 || misalign_o !== 1'b0 || rdata_o !== model_rdata) begin
                    miscompares++;
                    $display("FAIL stall_cycle k=%0d got req=%b we=%b addr=%h be=%b wd=%h rv=%b err=%b mis=%b rdata=%h; want we=%b addr=%h be=%b wd=%h rdata=%h",
                             k, bus_req_o, bus_we_o, bus_addr_o, bus_be_o, bus_wdata_o, rdata_valid_o, err_o,
                             misalign_o, rdata_o, wr, addr_e, be_e, wdata_e, model_rdata);
                end
            end else begin
                done = 1;
                vectors++;
                if (stall_n !== stall_e || rdata_valid_o !== (!mis_e && !tmo_e && !wr) || err_o !== tmo_e ||
                    misalign_o !== mis_e || bus_req_o !== 1'b0 || rdata_o !== new_rdata) begin
                    miscompares++;
                    $display("FAIL done_cycle rd=%b wr=%b w=%b a=%h dly=%0d got stall=%0d rv=%b err=%b mis=%b req=%b rdata=%h; want stall=%0d rv=%b err=%b mis=%b rdata=%h",
                             rd, wr, w, a, dly, stall_n, rdata_valid_o, err_o, misalign_o, bus_req_o, rdata_o,
                             stall_e, (!mis_e && !tmo_e && !wr), tmo_e, mis_e, new_rdata);
                end
                model_rdata = new_rdata;
                mem_read_ctrl_i = 1'b0;
                mem_write_ctrl_i = 1'b0;
            end
            @(posedge clk);
            #1;
        end
        bus_ack_i = 1'b0;
        if (!done) begin
            vectors++;
            miscompares++;
            $display("FAIL txn_timeout stall still high after %0d cycles, want release after %0d", k, stall_e);
            mem_read_ctrl_i = 1'b0;
            mem_write_ctrl_i = 1'b0;
            @(posedge clk);
            #1;
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        mem_read_ctrl_i = 0; mem_write_ctrl_i = 0; wr_width_i = 0; addr_i = 0; w_data_i = 0;
        bus_ack_i = 0; bus_rdata_i = 0;
        #3;
        vectors++;
        if ({bus_req_o, bus_we_o, bus_addr_o, bus_be_o, bus_wdata_o, stall_o, rdata_o, rdata_valid_o, err_o, misalign_o} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs req=%b we=%b addr=%h be=%b wd=%h stall=%b rdata=%h rv=%b err=%b mis=%b, want all 0",
                     bus_req_o, bus_we_o, bus_addr_o, bus_be_o, bus_wdata_o, stall_o, rdata_o, rdata_valid_o, err_o, misalign_o);
        end
        model_rdata = 32'h0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_sb();
        run_txn(1'b0, 1'b1, 3'b000, 32'h0000_1003, 32'h0000_00A5, 0, 32'h0);
        vectors++;
        if (bus_be_o !== 4'b1000 || bus_wdata_o !== 32'hA5A5A5A5 || bus_addr_o !== 32'h0000_1000 || bus_we_o !== 1'b1) begin
            miscompares++;
            $display("FAIL sb_lanes be=%b wd=%h addr=%h we=%b, want be=1000 wd=a5a5a5a5 addr=00001000 we=1",
                     bus_be_o, bus_wdata_o, bus_addr_o, bus_we_o);
        end
    endtask

    task automatic test_loads();
        run_txn(1'b1, 1'b0, 3'b000, 32'h0000_2002, 32'h0, 0, 32'h00F3_0000);
        vectors++;
        if (rdata_o !== 32'hFFFF_FFF3) begin
            miscompares++;
            $display("FAIL lb_sign rdata=%h want ffffff f3", rdata_o);
        end
        run_txn(1'b1, 1'b0, 3'b100, 32'h0000_2002, 32'h0, 1, 32'h00F3_0000);
        vectors++;
        if (rdata_o !== 32'h0000_00F3) begin
            miscompares++;
            $display("FAIL lbu_zero rdata=%h want 000000f3", rdata_o);
        end
        run_txn(1'b1, 1'b0, 3'b001, 32'h0000_2002, 32'h0, 0, 32'h8001_0000);
        vectors++;
        if (rdata_o !== 32'hFFFF_8001) begin
            miscompares++;
            $display("FAIL lh_sign rdata=%h want ffff8001", rdata_o);
        end
        // both controls high: the write wins and no load data is returned
        run_txn(1'b1, 1'b1, 3'b001, 32'h0000_2006, 32'h1234_BEEF, 2, 32'h5555_AAAA);
    endtask

    task automatic test_lw_wait();
        run_txn(1'b1, 1'b0, 3'b010, 32'h0000_4000, 32'h0, 5, 32'hDEAD_BEEF);
        vectors++;
        if (rdata_o !== 32'hDEAD_BEEF) begin
            miscompares++;
            $display("FAIL lw_wait rdata=%h want deadbeef", rdata_o);
        end
    endtask

    task automatic test_timeout();
        run_txn(1'b1, 1'b0, 3'b010, 32'h0000_5000, 32'h0, 20, 32'h0);
        vectors++;
        if (rdata_o !== 32'h0) begin
            miscompares++;
            $display("FAIL timeout_rdata rdata=%h want 00000000", rdata_o);
        end
        run_txn(1'b1, 1'b0, 3'b101, 32'h0000_5002, 32'h0, 14, 32'h9876_5432);
    endtask

`ifdef MEM_MISALIGN_CHK_EN
    task automatic test_misalign();
        run_txn(1'b0, 1'b1, 3'b010, 32'h0000_3002, 32'h1111_2222, 0, 32'h0);
        run_txn(1'b1, 1'b0, 3'b001, 32'h0000_3001, 32'h0, 0, 32'h0);
    endtask
`endif

    task automatic test_stray_ack();
        bus_ack_i = 1'b1;
        bus_rdata_i = 32'hCAFE_F00D;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vectors++;
            if (bus_req_o !== 1'b0 || stall_o !== 1'b0 || rdata_valid_o !== 1'b0 || err_o !== 1'b0 || rdata_o !== model_rdata) begin
                miscompares++;
                $display("FAIL stray_ack req=%b stall=%b rv=%b err=%b rdata=%h, want 0 0 0 0 %h",
                         bus_req_o, stall_o, rdata_valid_o, err_o, rdata_o, model_rdata);
            end
            @(posedge clk);
            #1;
        end
        bus_ack_i = 1'b0;
    endtask

    task automatic test_reset_mid_busy();
        mem_read_ctrl_i = 1'b1; wr_width_i = 3'b010; addr_i = 32'h0000_6000;
        @(posedge clk);
        #1;
        @(negedge clk);
        vectors++;
        if (bus_req_o !== 1'b1) begin
            miscompares++;
            $display("FAIL busy_before_reset req=%b want 1", bus_req_o);
        end
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (bus_req_o !== 1'b0 || stall_o !== 1'b0 || rdata_valid_o !== 1'b0 || err_o !== 1'b0 || rdata_o !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_mid_busy req=%b stall=%b rv=%b err=%b rdata=%h, want all 0",
                     bus_req_o, stall_o, rdata_valid_o, err_o, rdata_o);
        end
        model_rdata = 32'h0;
        @(posedge clk);
        #1;
        mem_read_ctrl_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            vectors++;
            if (bus_req_o !== 1'b0 || stall_o !== 1'b0 || rdata_valid_o !== 1'b0) begin
                miscompares++;
                $display("FAIL after_reset_idle req=%b stall=%b rv=%b, want 0 0 0", bus_req_o, stall_o, rdata_valid_o);
            end
        end
        run_txn(1'b1, 1'b0, 3'b000, 32'h0000_6001, 32'h0, 1, 32'h0000_7F00);
    endtask

    task automatic test_random();
        logic [1:0] op;
        int dly;
        for (int n = 0; n < 200; n++) begin
            op  = 2'($urandom_range(1, 3));
            dly = ($urandom_range(0, 9) == 0) ? $urandom_range(14, 18) : $urandom_range(0, 6);
            run_txn(op[0], op[1], 3'($urandom_range(0, 7)), $urandom, $urandom, dly, $urandom);
        end
    endtask

    initial begin
        test_reset();
        test_sb();
        test_loads();
        test_lw_wait();
        test_timeout();
`ifdef MEM_MISALIGN_CHK_EN
        test_misalign();
`endif
        test_stray_ack();
        test_random();
        test_reset_mid_busy();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not complete, vectors=%0d", vectors);
        $fatal(1);
    end
endmodule
